// File: rtl/parallel_recv_if.sv
// Word-stream bundle between the deserializer, the aligning receiver and its consumer.
interface parallel_recv_if;
  logic        DIPUSH;
  logic [31:0] DIN;
  logic        DOPUSH;
  logic [31:0] DOUT;
  logic        LOCKED;
  logic [4:0]  OFFSET;
  logic [15:0] ERR_CNT;

  modport master (
    output DIPUSH, DIN,
    input  DOPUSH, DOUT, LOCKED, OFFSET, ERR_CNT
  );

  modport slave (
    input  DIPUSH, DIN,
    output DOPUSH, DOUT, LOCKED, OFFSET, ERR_CNT
  );
endinterface

// File: rtl/parallel_recv.sv
// Aligning receiver: hunts the bit offset of the align marker in a rotated word stream,
// forwards aligned payload and checks it against an incrementing sequence.
module parallel_recv #(
  parameter logic [31:0] ALIGN_PAT = 32'hF731_8CEF,
  parameter int unsigned LOSS_N    = 4
) (
  input  logic          CLK,
  input  logic          RSTX,
  input  logic          CLR,
  parallel_recv_if.slave link
);

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_SEED  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [3:0] LOSS_LIM = 4'(LOSS_N);

  logic [1:0]  state_q, state_d;
  logic [31:0] prev_q, prev_d;
  logic        prev_valid_q, prev_valid_d;
  logic [31:0] expected_q, expected_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic        dopush_q, dopush_d;
  logic [31:0] dout_q, dout_d;
  logic        locked_q, locked_d;
  logic [4:0]  offset_q, offset_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [63:0] win;
  logic [63:0] win_sh;
  logic [63:0] probe;
  logic [31:0] cand;
  logic        stop;
  logic        hit;
  logic [4:0]  hit_k;

  function automatic logic is_train(input logic [31:0] x);
    return (x == 32'h0000_0000) || (x == 32'hAAAA_AAAA) || (x == 32'h5555_5555);
  endfunction

  // Word at the locked offset: shifting the 64-bit history left by k puts A(k) in the upper half.
  always_comb begin
    win    = {prev_q, link.DIN};
    win_sh = win << offset_q;
    cand   = win_sh[63:32];
    stop   = is_train(cand) || (cand == ALIGN_PAT);
  end

  // Lowest matching offset wins; later hits are ignored once one is found.
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    probe = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      probe = win << k;
      if (!hit && (probe[63:32] == ALIGN_PAT)) begin
        hit   = 1'b1;
        hit_k = 5'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    expected_d   = expected_q;
    miss_cnt_d   = miss_cnt_q;
    dopush_d     = 1'b0;
    dout_d       = dout_q;
    locked_d     = locked_q;
    offset_d     = offset_q;
    err_cnt_d    = err_cnt_q;

    if (CLR) begin
      state_d      = ST_HUNT;
      prev_d       = '0;
      prev_valid_d = 1'b0;
      expected_d   = '0;
      miss_cnt_d   = '0;
      dout_d       = '0;
      locked_d     = 1'b0;
      offset_d     = '0;
      err_cnt_d    = '0;
    end else if (link.DIPUSH) begin
      prev_d       = link.DIN;
      prev_valid_d = 1'b1;
      case (state_q)
        ST_HUNT: begin
          if (prev_valid_q && hit) begin
            offset_d = hit_k;
            locked_d = 1'b1;
            state_d  = ST_SEED;
          end
        end
        ST_SEED: begin
          if (stop) begin
            locked_d = 1'b0;
            state_d  = ST_HUNT;
          end else begin
            dout_d     = cand;
            dopush_d   = 1'b1;
            expected_d = cand + 32'd1;
            miss_cnt_d = '0;
            state_d    = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (stop) begin
            locked_d = 1'b0;
            state_d  = ST_HUNT;
          end else begin
            dout_d     = cand;
            dopush_d   = 1'b1;
            expected_d = cand + 32'd1;
            if (cand == expected_q) begin
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
              if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
              end
              if (miss_cnt_q + 4'd1 == LOSS_LIM) begin
                locked_d = 1'b0;
                state_d  = ST_HUNT;
              end
            end
          end
        end
        default: begin
          locked_d = 1'b0;
          state_d  = ST_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q      <= ST_HUNT;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      expected_q   <= '0;
      miss_cnt_q   <= '0;
      dopush_q     <= 1'b0;
      dout_q       <= '0;
      locked_q     <= 1'b0;
      offset_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      expected_q   <= expected_d;
      miss_cnt_q   <= miss_cnt_d;
      dopush_q     <= dopush_d;
      dout_q       <= dout_d;
      locked_q     <= locked_d;
      offset_q     <= offset_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign link.DOPUSH  = dopush_q;
  assign link.DOUT    = dout_q;
  assign link.LOCKED  = locked_q;
  assign link.OFFSET  = offset_q;
  assign link.ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_parallel_recv.sv
// Bench for parallel_recv: a behavioural receiver model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized rotated streams.
module tb_parallel_recv;
  localparam logic [31:0] PAT  = 32'hF731_8CEF;
  localparam int          LOSS = 4;

  logic clk = 1'b0;
  logic rstx = 1'b0;
  logic clr = 1'b0;

  parallel_recv_if bus ();

  parallel_recv #(.ALIGN_PAT(PAT), .LOSS_N(LOSS)) dut (
    .CLK  (clk),
    .RSTX (rstx),
    .CLR  (clr),
    .link (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;          // 0 searching, 1 waiting for first payload, 2 tracking sequence
  logic [31:0] m_prev, m_exp, m_dout;
  bit          m_pv, m_push, m_locked;
  int          m_off, m_err, m_miss;

  function automatic logic [31:0] view(input logic [31:0] p, input logic [31:0] d, input int kk);
    logic [63:0] w;
    w = {p, d};
    return 32'(w >> (32 - kk));
  endfunction

  function automatic bit training(input logic [31:0] x);
    return x == 32'h0 || x == 32'hAAAA_AAAA || x == 32'h5555_5555;
  endfunction

  task automatic m_clear();
    m_mode = 0; m_prev = 0; m_exp = 0; m_dout = 0; m_pv = 0;
    m_push = 0; m_locked = 0; m_off = 0; m_err = 0; m_miss = 0;
  endtask

  always @(posedge clk or negedge rstx) begin
    logic [31:0] d, a;
    bit found;
    if (!rstx || clr) begin
      m_clear();
    end else begin
      m_push = 0;
      if (bus.DIPUSH) begin
        d = bus.DIN;
        if (m_mode == 0) begin
          found = 0;
          if (m_pv) begin
            for (int kk = 0; kk < 32; kk++) begin
              if (!found && view(m_prev, d, kk) == PAT) begin
                found = 1; m_off = kk; m_mode = 1; m_locked = 1;
              end
            end
          end
        end else begin
          a = view(m_prev, d, m_off);
          if (training(a) || a == PAT) begin
            m_mode = 0; m_locked = 0;
          end else begin
            m_push = 1; m_dout = a;
            if (m_mode == 1) begin
              m_mode = 2; m_miss = 0;
            end else if (a != m_exp) begin
              if (m_err < 65535) m_err++;
              m_miss++;
              if (m_miss == LOSS) begin m_mode = 0; m_locked = 0; end
            end else begin
              m_miss = 0;
            end
            m_exp = a + 32'd1;
          end
        end
        m_prev = d; m_pv = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] pushes[$];

  always @(negedge clk) begin
    chk("DOPUSH", 32'(bus.DOPUSH), 32'(m_push));
    chk("DOUT", bus.DOUT, m_dout);
    chk("LOCKED", 32'(bus.LOCKED), 32'(m_locked));
    chk("OFFSET", 32'(bus.OFFSET), 32'(m_off));
    chk("ERR_CNT", 32'(bus.ERR_CNT), 32'(m_err));
    if (bus.DOPUSH) pushes.push_back(bus.DOUT);
  end

  // ---------------- stimulus ----------------
  int          k;
  logic [31:0] last_l;
  bit          gapp;

  task automatic cyc(input logic push, input logic [31:0] d, input logic c);
    @(negedge clk);
    bus.DIPUSH = push;
    bus.DIN    = d;
    clr        = c;
  endtask

  task automatic settle();
    cyc(1'b0, $urandom, 1'b0);
    #1;
  endtask

  // Transmitter-side word L, rotated into the receive framing by k bits.
  task automatic send(input logic [31:0] l);
    logic [63:0] pair;
    if (gapp && $urandom_range(0, 3) == 0) cyc(1'b0, $urandom, 1'b0);
    pair   = {last_l, l};
    last_l = l;
    cyc(1'b1, 32'(pair >> k), 1'b0);
  endtask

  task automatic restart(input int newk);
    cyc(1'b0, 32'h0, 1'b1);
    k = newk; last_l = 0;
    pushes.delete();
  endtask

  task automatic lead_in();
    send(32'h0);
    repeat (8) send(32'hAAAA_AAAA);
    send(PAT);
  endtask

  initial begin
    int n, r, sz;
    logic [31:0] w, base;
    bus.DIPUSH = 0; bus.DIN = 0;
    gapp = 0; k = 0; last_l = 0;
    m_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_LOCKED", 32'(bus.LOCKED), 0);
    chk("rst_DOUT", bus.DOUT, 0);
    chk("rst_ERR", 32'(bus.ERR_CNT), 0);
    @(negedge clk);
    rstx = 1;

    // aligned stream
    restart(0);
    lead_in();
    settle();
    chk("k0_prelock", 32'(bus.LOCKED), 0);
    send(32'd1);
    settle();
    chk("k0_locked", 32'(bus.LOCKED), 1);
    chk("k0_offset", 32'(bus.OFFSET), 0);
    send(32'd2); send(32'd3); send(32'd4);
    settle();
    chk("k0_npush", pushes.size(), 3);
    chk("k0_first", pushes[0], 32'd1);
    chk("k0_second", pushes[1], 32'd2);
    chk("k0_err", 32'(bus.ERR_CNT), 0);

    // rotated stream
    restart(7);
    lead_in();
    send(32'd1); send(32'd2); send(32'd3); send(32'd4); send(32'd5);
    settle();
    chk("k7_offset", 32'(bus.OFFSET), 7);
    chk("k7_npush", pushes.size(), 4);
    chk("k7_p0", pushes[0], 32'd1);
    chk("k7_p1", pushes[1], 32'd2);
    chk("k7_p2", pushes[2], 32'd3);

    // corrupt payload word
    restart(0);
    send(32'h0); send(32'hAAAA_AAAA); send(PAT);
    send(32'd10); send(32'd11); send(32'h1234); send(32'd13); send(32'd14); send(32'd15);
    settle();
    chk("bad_err", 32'(bus.ERR_CNT), 2);
    chk("bad_locked", 32'(bus.LOCKED), 1);
    chk("bad_npush", pushes.size(), 5);
    chk("bad_p2", pushes[2], 32'h1234);
    chk("bad_p4", pushes[4], 32'd14);

    // loss of lock
    send(32'h100); send(32'h300); send(32'h500); send(32'h700); send(32'h900);
    settle();
    chk("loss_locked", 32'(bus.LOCKED), 0);
    chk("loss_err", 32'(bus.ERR_CNT), 6);
    send(32'h111); send(32'h222);
    settle();
    chk("loss_nopush", pushes.size(), 10);

    // retraining across a counter wrap
    send(PAT); send(32'hFFFF_FFFD); send(32'hFFFF_FFFE); send(32'hFFFF_FFFF);
    send(32'h0); send(32'hAAAA_AAAA);
    settle();
    chk("wrap_unlocked", 32'(bus.LOCKED), 0);
    chk("wrap_err", 32'(bus.ERR_CNT), 6);
    send(PAT); send(32'h1_0000); send(32'h1_0001); send(32'd5);
    settle();
    chk("relock", 32'(bus.LOCKED), 1);
    chk("reseed", pushes[pushes.size()-2], 32'h1_0000);
    chk("reseed_next", pushes[pushes.size()-1], 32'h1_0001);
    chk("relock_err", 32'(bus.ERR_CNT), 6);

    // CLR mid-CHECK, then first word after clear must not lock
    cyc(1'b1, PAT, 1'b1);
    settle();
    chk("clr_locked", 32'(bus.LOCKED), 0);
    chk("clr_err", 32'(bus.ERR_CNT), 0);
    chk("clr_dout", bus.DOUT, 0);
    last_l = 0;
    send(PAT);
    settle();
    chk("clr_nolock", 32'(bus.LOCKED), 0);
    send(32'd1); send(32'd2); send(32'd9); send(32'd20);
    settle();
    chk("pre_rst_err", 32'(bus.ERR_CNT), 1);

    // asynchronous reset mid-cycle
    bus.DIPUSH = 0;
    #2 rstx = 0;
    #1;
    chk("arst_locked", 32'(bus.LOCKED), 0);
    chk("arst_err", 32'(bus.ERR_CNT), 0);
    chk("arst_dout", bus.DOUT, 0);
    @(negedge clk);
    rstx = 1;
    last_l = 0;
    send(PAT);
    settle();
    chk("arst_nolock", 32'(bus.LOCKED), 0);

    // randomized rotated streams
    gapp = 1;
    for (int t = 0; t < 16; t++) begin
      k = $urandom_range(0, 31);
      repeat ($urandom_range(1, 4)) begin
        r = $urandom_range(0, 2);
        send(r == 0 ? 32'h0 : (r == 1 ? 32'hAAAA_AAAA : 32'h5555_5555));
      end
      send(PAT);
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      n = $urandom_range(10, 60);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 99);
        if (r < 8)       w = $urandom;
        else if (r < 10) w = PAT;
        else if (r < 12) w = 32'h5555_5555;
        else if (r < 13) w = 32'h0;
        else             w = base;
        send(w);
        base = w + 32'd1;
      end
      if ($urandom_range(0, 3) == 0) cyc(1'b1, $urandom, 1'b1);
    end
    settle();

    sz = pushes.size();
    chk("rand_pushed", 32'(sz > 10), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
